// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared constants and the counter-width helper for the switch
//            debouncer family.
// Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

  // Fabric clock frequency feeding the debouncers.
  localparam int c_CLK_HZ = 25000000;

  // 10 ms worth of fabric clock cycles (250000 at 25 MHz).
  localparam int c_DEBOUNCE_LIMIT_10MS_25MHZ = c_CLK_HZ / 100;

  // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Counter width for a given limit; never narrower than one bit so a limit
  // of 1 still yields a legal vector.
  function automatic int cnt_width(input int limit);
    return (clog2(limit) < 1) ? 1 : clog2(limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One debounced switch: input synchroniser, mismatch counter,
//            debounced level and registered rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_LIMIT = 4,
  parameter int   SYNC_STAGES    = 2,
  parameter logic INIT_STATE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       count;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // Synchroniser chain; preloaded with the reset level so releasing reset
  // never presents a fake transition to the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{INIT_STATE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive mismatches; flip the level and pulse on the last one.
  // Any agreeing sample throws away the partial count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= INIT_STATE;
      count <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        level <= s;
        count <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : debounce_multi
// Purpose  : N independent switch debouncers with per-channel edge pulses
//            and a registered "something changed" flag.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int                NUM_CH         = 4,
  parameter int                DEBOUNCE_LIMIT = c_DEBOUNCE_LIMIT_10MS_25MHZ,
  parameter int                SYNC_STAGES    = 2,
  parameter logic [NUM_CH-1:0] INIT_STATE     = {NUM_CH{1'b0}}
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_CH-1:0] i_Switch,
  output logic [NUM_CH-1:0] o_Switch,
  output logic [NUM_CH-1:0] o_Rise,
  output logic [NUM_CH-1:0] o_Fall,
  output logic              o_Any_Change
);

  // One self-contained debouncer per switch; channels share nothing but
  // clock and reset.
  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .SYNC_STAGES    (SYNC_STAGES),
      .INIT_STATE     (INIT_STATE[n])
    ) u_channel (
      .clk   (i_Clk),
      .rst   (i_Rst),
      .raw   (i_Switch[n]),
      .level (o_Switch[n]),
      .rise  (o_Rise[n]),
      .fall  (o_Fall[n])
    );
  end

  // Summary flag trails the per-channel pulses by one cycle.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Any_Change <= 1'b0;
    end else begin
      o_Any_Change <= |(o_Rise | o_Fall);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_multi
// Purpose  : Directed bench for debounce_multi (4 channels, limit 4,
//            2 sync stages); a second instance uses INIT_STATE = 4'b0010.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] sw_q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_chg;

  logic       rst2;
  logic [3:0] sw2;
  logic [3:0] sw2_q;
  logic [3:0] rise2;
  logic [3:0] fall2;
  logic       any2;

  int passed;
  int total;

  typedef struct {
    logic [3:0] sw;
    logic [3:0] exp_sw;
    logic [3:0] exp_rise;
    logic [3:0] exp_fall;
    logic       exp_any;
  } vec_t;

  vec_t tbl [20];

  debounce_multi #(
    .NUM_CH         (4),
    .DEBOUNCE_LIMIT (4),
    .SYNC_STAGES    (2),
    .INIT_STATE     (4'b0000)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Switch     (sw),
    .o_Switch     (sw_q),
    .o_Rise       (rise),
    .o_Fall       (fall),
    .o_Any_Change (any_chg)
  );

  debounce_multi #(
    .NUM_CH         (4),
    .DEBOUNCE_LIMIT (4),
    .SYNC_STAGES    (2),
    .INIT_STATE     (4'b0010)
  ) dut_init (
    .i_Clk        (clk),
    .i_Rst        (rst2),
    .i_Switch     (sw2),
    .o_Switch     (sw2_q),
    .o_Rise       (rise2),
    .o_Fall       (fall2),
    .o_Any_Change (any2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total = total + 1;
    if (act === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [3:0] e_sw, input logic [3:0] e_r,
                            input logic [3:0] e_f, input logic e_any);
    check({tag, " switch"}, sw_q, e_sw);
    check({tag, " rise"},   rise, e_r);
    check({tag, " fall"},   fall, e_f);
    check({tag, " any"},    {3'b000, any_chg}, {3'b000, e_any});
  endtask

  task automatic check_init(input string tag, input logic [3:0] e_sw, input logic [3:0] e_r,
                            input logic [3:0] e_f, input logic e_any);
    check({tag, " switch"}, sw2_q, e_sw);
    check({tag, " rise"},   rise2, e_r);
    check({tag, " fall"},   fall2, e_f);
    check({tag, " any"},    {3'b000, any2}, {3'b000, e_any});
  endtask

  // Hard stop if something stalls the run.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b0;
    sw     = 4'b1111;
    rst2   = 1'b0;
    sw2    = 4'b0010;

    // Edge-indexed vectors: sw is applied before edge i+1, outputs checked
    // after it. Ch0 clean rise, ch1 3-cycle glitch, ch2 interrupted count,
    // then ch0 fall and ch3 rise together.
    tbl[0]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{4'b0111, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{4'b0101, 4'b0001, 4'b0001, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    tbl[7]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0101, 4'b0101, 4'b0100, 4'b0000, 1'b0};
    tbl[10] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b1};
    tbl[11] = '{4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[12] = '{4'b1100, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[13] = '{4'b1100, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[14] = '{4'b1100, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[15] = '{4'b1100, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[16] = '{4'b1100, 4'b0101, 4'b0000, 4'b0000, 1'b0};
    tbl[17] = '{4'b1100, 4'b1100, 4'b1000, 4'b0001, 1'b0};
    tbl[18] = '{4'b1100, 4'b1100, 4'b0000, 4'b0000, 1'b1};
    tbl[19] = '{4'b1100, 4'b1100, 4'b0000, 4'b0000, 1'b0};

    // Async reset with switches already high: outputs clear with no edge.
    tick();
    rst = 1'b1;
    #1;
    check_main("async reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #2;
    rst = 1'b0;

    // Release: level holds for 5 edges, flips on the 6th with a rise pulse.
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_main($sformatf("release edge%0d", e), 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    check_main("release edge6", 4'b1111, 4'b1111, 4'b0000, 1'b0);
    tick();
    check_main("release edge7", 4'b1111, 4'b0000, 4'b0000, 1'b1);

    // Back to an all-low baseline for the vector table.
    rst = 1'b1;
    sw  = 4'b0000;
    #1;
    check_main("reset to zero", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #2;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      sw = tbl[i].sw;
      tick();
      check_main($sformatf("vec%0d", i), tbl[i].exp_sw, tbl[i].exp_rise,
                 tbl[i].exp_fall, tbl[i].exp_any);
      check($sformatf("vec%0d rise&fall", i), rise & fall, 4'b0000);
    end

    // Second instance: reset value 4'b0010 appears immediately.
    rst2 = 1'b1;
    sw2  = 4'b0010;
    #1;
    check_init("init reset", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    #2;
    rst2 = 1'b0;

    // Ch0 up and ch1 down start counting, then reset lands mid-count.
    sw2 = 4'b0001;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check_init($sformatf("midcount edge%0d", e), 4'b0010, 4'b0000, 4'b0000, 1'b0);
    end
    rst2 = 1'b1;
    #1;
    check_init("midcount reset", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    #2;
    rst2 = 1'b0;

    // Abandoned count: the full 6-edge latency restarts from release.
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_init($sformatf("restart edge%0d", e), 4'b0010, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    check_init("restart edge6", 4'b0001, 4'b0001, 4'b0010, 1'b0);
    tick();
    check_init("restart edge7", 4'b0001, 4'b0000, 4'b0000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel switch/button debouncer with a built-in input synchroniser and per-channel edge-pulse outputs.
- Successor to the single-channel fixed-limit debouncer; sits between raw board switches/buttons and the UART control/test logic on the 25 MHz fabric clock.
- Each channel has its own counter and runs independently. A channel's output flips only after its synchronised input has differed from the debounced state for DEBOUNCE_LIMIT consecutive cycles.

Parameters:
- NUM_CH, 4, number of independent switch channels (>=1).
- DEBOUNCE_LIMIT, 250000, consecutive mismatching cycles required before the output flips (>=1); 10 ms at 25 MHz.
- SYNC_STAGES, 2, synchroniser flop depth per channel (2 or 3).
- INIT_STATE, {NUM_CH{1'b0}}, per-channel reset value of the debounced state; NUM_CH bits wide.

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Switch  input  NUM_CH  raw, asynchronous switch levels.
- o_Switch  output  NUM_CH  debounced levels.
- o_Rise  output  NUM_CH  one-cycle pulse when the channel's debounced level goes 0->1.
- o_Fall  output  NUM_CH  one-cycle pulse when the channel's debounced level goes 1->0.
- o_Any_Change  output  1  registered OR over all bits of o_Rise and o_Fall, delayed one cycle.

Behaviour:
- Reset (i_Rst=1, async, takes effect immediately, no clock needed):
  - all synchroniser flops of channel n = INIT_STATE[n]
  - o_Switch = INIT_STATE
  - all counters = 0
  - o_Rise = o_Fall = 0, o_Any_Change = 0
  - Loading the synchronisers with INIT_STATE prevents a spurious edge at reset release.
- Reset asserted mid-count abandons the count. No pulse is generated for the abandoned count.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel; s[n] is its last stage.
- Counter width is max(1, clog2(DEBOUNCE_LIMIT)). The counter never exceeds DEBOUNCE_LIMIT-1, so it cannot wrap.
- Per channel, on every rising i_Clk edge:
  - s[n] == o_Switch[n]: count <= 0; any partial count is discarded, even if one cycle short.
  - s[n] != o_Switch[n] and count < DEBOUNCE_LIMIT-1: count <= count+1.
  - s[n] != o_Switch[n] and count == DEBOUNCE_LIMIT-1: o_Switch[n] <= s[n]; count <= 0; o_Rise[n] <= s[n]; o_Fall[n] <= ~s[n].
  - All other cycles: o_Rise[n] <= 0, o_Fall[n] <= 0. Pulses last exactly one cycle and change on the same edge as o_Switch.
- DEBOUNCE_LIMIT=1: a single mismatching synchronised sample flips the output.
- Latency: a clean input step captured at edge k appears on o_Switch at edge k+SYNC_STAGES+DEBOUNCE_LIMIT-1, i.e. the (SYNC_STAGES+DEBOUNCE_LIMIT)th edge counting edge k as the first.
- A glitch shorter than DEBOUNCE_LIMIT synchronised cycles produces no output change and no pulse.
- Channels are fully independent. Simultaneous flips on several channels each raise their own pulse in the same cycle.
- o_Any_Change is high for one cycle, one cycle after any pulse.
- o_Rise[n] and o_Fall[n] are never high together.

Decomposition:
- Shared package (debounce_pkg):
  - c_DEBOUNCE_LIMIT_10MS_25MHZ = 250000
  - c_CLK_HZ = 25000000
  - clog2 helper function for counter width.
- Sub-module debounce_channel holds one synchroniser, counter, state and edge logic per channel.
- The top instantiates NUM_CH copies in a generate loop and registers o_Any_Change.

Test Plan (NUM_CH=4, DEBOUNCE_LIMIT=4, SYNC_STAGES=2, INIT_STATE=4'b0000 unless stated):
- Reset: hold i_Switch=4'b1111, pulse i_Rst between clock edges -> outputs are 0 immediately with no clock; after release, o_Switch stays 0 for 5 edges and goes 4'b1111 on the 6th edge with o_Rise=4'b1111 for one cycle.
- Clean step: ch0 0->1 captured at edge k -> o_Switch[0]=1 and o_Rise[0]=1 at edge k+5; o_Rise[0]=0 at edge k+6; o_Any_Change=1 only at edge k+6.
- Glitch: ch1 high for 3 cycles then low -> o_Switch[1] stays 0; no pulse on o_Rise or o_Fall.
- Interrupted count: ch2 high 3 cycles, low 1 cycle, high 4+ cycles -> flips only after the second run completes (count restarts from 0); one o_Rise pulse total.
- Simultaneous: ch0 1->0 and ch3 0->1 in the same cycle -> o_Fall=4'b0001 and o_Rise=4'b1000 on the same edge; a single o_Any_Change pulse.
- Mid-count reset: ch1 high 2 cycles, assert i_Rst with INIT_STATE=4'b0010 -> o_Switch[1]=1 immediately; no o_Rise or o_Fall at reset release.
